// File: rtl/fourbit_flag_reg_pkg.sv
// Shared op codes, FSM state codes and command entry layout for the flag register.
// Imported by fourbit_cmd_fifo and fourbit_flag_reg.
package fourbit_flag_reg_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_STALL = 2'b10;

  // 9-bit queued command: {op, index, value, data}
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] index;
    logic       value;
    logic [3:0] data;
  } cmd_t;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] m;
    case (idx)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0010;
      2'd2:    m = 4'b0100;
      2'd3:    m = 4'b1000;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fourbit_flag_reg_if.sv
// Command and snapshot handshake bundle for fourbit_flag_reg.
// master = command producer / snapshot consumer, slave = the flag register.
interface fourbit_flag_reg_if;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_index;
  logic       cmd_value;
  logic [3:0] cmd_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_index, cmd_value, cmd_data, out_ready,
    input  cmd_ready, out_valid, out_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index, cmd_value, cmd_data, out_ready,
    output cmd_ready, out_valid, out_flags
  );

endinterface

// File: rtl/fourbit_bitset.sv
// Single-bit writer: copies a 4-bit word with bit 'index' replaced by 'value'.
module fourbit_bitset (
  input  logic [3:0] in_flags,
  input  logic [1:0] index,
  input  logic       value,
  output logic [3:0] out_flags
);

  // Replace the addressed bit, keep the rest
  always_comb begin
    out_flags        = in_flags;
    out_flags[index] = value;
  end

endmodule

// File: rtl/fourbit_cmd_fifo.sv
// Command FIFO for the flag register: DEPTH entries of cmd_t, registered full/empty/count.
module fourbit_cmd_fifo
  import fourbit_flag_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  cmd_t          wdata,
  output cmd_t          rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] PSTEP_C = AW'(1);

  cmd_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A full FIFO refuses the push even when a pop frees a slot this cycle
  assign do_push_s = push & ~full_r;
  assign do_pop_s  = pop & ~empty_r;

  // Occupancy after this edge
  always_comb begin
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (!do_push_s && do_pop_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, status flags and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PSTEP_C;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PSTEP_C;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == {CW{1'b0}});
    end
  end

  // Entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/fourbit_flag_reg.sv
// Queued 4-bit flag register: applies one WRITE/TOGGLE/CLEAR/LOAD per cycle and offers each result.
// Define FOURBIT_FLAG_REG_IRQ_EN to add the irq/irq_ack rising-bit interrupt.
module fourbit_flag_reg
  import fourbit_flag_reg_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  fourbit_flag_reg_if.slave bus,
  output logic [3:0]        flags,
  output logic [CW-1:0]     count
`ifdef FOURBIT_FLAG_REG_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_ack
`endif
);

  localparam logic [CW-1:0] ONE_C = CW'(1);

  cmd_t          wcmd_s;
  cmd_t          head_s;
  logic          full_s;
  logic          empty_s;
  logic [CW-1:0] count_s;
  logic          push_s;
  logic          issue_s;
  logic          work_nxt_s;
  logic          ov_nxt_s;
  logic [3:0]    bitset_s;
  logic [3:0]    next_s;
  logic [3:0]    flags_r;
  logic [3:0]    out_flags_r;
  logic          out_valid_r;
  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;

  assign wcmd_s = {bus.cmd_op, bus.cmd_index, bus.cmd_value, bus.cmd_data};
  assign push_s = bus.cmd_valid & ~full_s;

  fourbit_cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.cmd_valid),
    .pop   (issue_s),
    .wdata (wcmd_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  fourbit_bitset u_bitset (
    .in_flags  (flags_r),
    .index     (head_s.index),
    .value     (head_s.value),
    .out_flags (bitset_s)
  );

  // IDLE always has an empty FIFO, so the state gate never blocks real work
  assign issue_s = (state_r != ST_IDLE) & ~empty_s & (~out_valid_r | bus.out_ready);

  // Result of the head command applied to the live flags
  always_comb begin
    case (head_s.op)
      OP_WRITE:  next_s = bitset_s;
      OP_TOGGLE: next_s = flags_r ^ onehot4(head_s.index);
      OP_CLEAR:  next_s = 4'b0000;
      OP_LOAD:   next_s = head_s.data;
      default:   next_s = flags_r;
    endcase
  end

  // Snapshot valid after this edge
  always_comb begin
    ov_nxt_s = out_valid_r;
    if (issue_s) begin
      ov_nxt_s = 1'b1;
    end else if (bus.out_ready) begin
      ov_nxt_s = 1'b0;
    end else begin
      ov_nxt_s = out_valid_r;
    end
  end

  assign work_nxt_s = push_s | (count_s > ONE_C) | (~empty_s & ~issue_s);

  // Issue-gating state machine
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (push_s) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!work_nxt_s && !ov_nxt_s) begin
          state_nxt_s = ST_IDLE;
        end else if (work_nxt_s && ov_nxt_s && !bus.out_ready) begin
          state_nxt_s = ST_STALL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_STALL: begin
        if (bus.out_ready) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_STALL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Flag word, snapshot and state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r     <= 4'b0000;
      out_flags_r <= 4'b0000;
      out_valid_r <= 1'b0;
      state_r     <= ST_IDLE;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= ov_nxt_s;
      if (issue_s) begin
        flags_r     <= next_s;
        out_flags_r <= next_s;
      end
    end
  end

  assign bus.cmd_ready = ~full_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_flags = out_flags_r;
  assign flags         = flags_r;
  assign count         = count_s;

`ifdef FOURBIT_FLAG_REG_IRQ_EN
  logic [3:0] pending_r;
  logic [3:0] pend_nxt_s;
  logic       irq_r;

  // An ack clears old pending bits, but a bit rising on the same edge survives
  always_comb begin
    pend_nxt_s = pending_r;
    if (irq_ack) begin
      pend_nxt_s = 4'b0000;
    end else begin
      pend_nxt_s = pending_r;
    end
    if (issue_s) begin
      pend_nxt_s = pend_nxt_s | (next_s & ~flags_r);
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Pending bits and interrupt line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 4'b0000;
      irq_r     <= 1'b0;
    end else begin
      pending_r <= pend_nxt_s;
      irq_r     <= |pend_nxt_s;
    end
  end

  assign irq = irq_r;
`endif

endmodule
